// File: rtl/pwm_duty_decoder.sv
// ---------------------------------------------------------------------------
// pwm_duty_decoder
//
// Measures the duty of eight asynchronous PWM lines over a fixed frame of
// PERIOD clock cycles and exposes the eight 7-bit high-counts in parallel
// (duty_out) and, on request, as a 56-bit serial stream.
//
// Ports
//   clk         sole clock, rising edge
//   reset       asynchronous, active-high
//   pwm_in      8 asynchronous PWM lines, channel c on bit c
//   duty_out    captured high-counts, channel c on bits [7c+6:7c]
//   duty_valid  one-cycle pulse when duty_out has just been updated
//   rd_start    request a serial readout of duty_out
//   busy        serial readout in progress
//   ser_out     serial data bit (0 when ser_valid is low)
//   ser_valid   ser_out carries a valid bit
//   ser_last    marks the 56th (final) bit of a readout
// ---------------------------------------------------------------------------
module pwm_duty_decoder #(
  parameter int PERIOD = 100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  pwm_in,
  output logic [55:0] duty_out,
  output logic        duty_valid,
  input  logic        rd_start,
  output logic        busy,
  output logic        ser_out,
  output logic        ser_valid,
  output logic        ser_last
);

  localparam int          NUM_CH   = 8;
  localparam int          CNT_W    = 7;
  localparam logic [6:0]  LAST_CNT = 7'(PERIOD - 1);
  localparam logic [5:0]  LAST_BIT = 6'd55;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  logic [7:0]       sync_meta;
  logic [7:0]       sync_q;
  logic [6:0]       frame_cnt;
  logic             frame_end;
  logic [CNT_W-1:0] high_cnt [NUM_CH];

  state_t           state;
  state_t           state_next;
  logic             load;
  logic [55:0]      shift_reg;
  logic [55:0]      snapshot;
  logic [5:0]       bit_cnt;

  // Two-flop synchronizer per channel; sync_q is the only copy of the
  // PWM lines that the rest of the design may look at.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_meta <= '0;
      sync_q    <= '0;
    end else begin
      sync_meta <= pwm_in;
      sync_q    <= sync_meta;
    end
  end

  // Free-running frame counter; the cycle at PERIOD-1 is the capture cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt <= '0;
    end else if (frame_end) begin
      frame_cnt <= '0;
    end else begin
      frame_cnt <= frame_cnt + 7'd1;
    end
  end

  assign frame_end = (frame_cnt == LAST_CNT);

  // Per-channel high counters. On the capture cycle the current sample is
  // folded into the captured value while the counter restarts from zero, so
  // every synchronized sample lands in exactly one frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        high_cnt[c] <= '0;
      end
      duty_out   <= '0;
      duty_valid <= 1'b0;
    end else begin
      duty_valid <= frame_end;
      for (int c = 0; c < NUM_CH; c++) begin
        if (frame_end) begin
          duty_out[CNT_W*c +: CNT_W] <= high_cnt[c] + {6'd0, sync_q[c]};
          high_cnt[c]                <= '0;
        end else begin
          high_cnt[c] <= high_cnt[c] + {6'd0, sync_q[c]};
        end
      end
    end
  end

  // Reorder duty_out so that channel 0 sits at the top of the shift
  // register with its bit 6 first; shifting left then yields channel 0
  // MSB-first, followed by channels 1..7.
  always_comb begin
    snapshot = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      snapshot[55 - CNT_W*c -: CNT_W] = duty_out[CNT_W*c +: CNT_W];
    end
  end

  // Readout state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Readout next-state and outputs. Outputs are decoded from the state so
  // that an asynchronous reset silences the serial port immediately.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    busy       = 1'b0;
    ser_valid  = 1'b0;
    ser_out    = 1'b0;
    ser_last   = 1'b0;
    case (state)
      IDLE: begin
        if (rd_start) begin
          load       = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        busy      = 1'b1;
        ser_valid = 1'b1;
        ser_out   = shift_reg[55];
        if (bit_cnt == LAST_BIT) begin
          ser_last   = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Shift register and bit counter. The snapshot is taken from the
  // registered duty_out, so a capture on the same edge is not seen, and
  // later captures cannot disturb a readout in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else if (load) begin
      shift_reg <= snapshot;
      bit_cnt   <= '0;
    end else if (state == SHIFT) begin
      shift_reg <= {shift_reg[54:0], 1'b0};
      bit_cnt   <= bit_cnt + 6'd1;
    end
  end

endmodule
